pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage ARM pipeline. It drives the enable and flush inputs of the fetch/decode, register-fetch/execute and execute/memory pipeline registers, and the operand forwarding selects for the register-fetch/execute stage. It also inserts load-use bubbles, squashes wrong-path instructions after a taken branch, and freezes the pipeline while data memory is busy. A saturating stall counter is exported for performance measurement.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/fwd_select.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SQUASH   = 2'd1,
    MEM_WAIT = 2'd2
  } ctrlState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int REG_PC = 15;

endpackage

// File: rtl/fwd_select.sv
// Operand forward select for one source register: youngest producer wins.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] exRd,
  input  logic              exRegWrite,
  input  logic              exIsLoad,
  input  logic [ADDR_W-1:0] memRd,
  input  logic              memRegWrite,
  input  logic [ADDR_W-1:0] wbRd,
  input  logic              wbRegWrite,
  output logic [1:0]        fwdSel
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);

  // NOTE: assigning a default before any branch keeps this block purely
  // combinational; a path that leaves fwdSel unassigned would infer a latch.
  always_comb begin
    fwdSel = FWD_RF;
    if (src != PC_ADDR) begin
      // A load in EX has no data yet; the load-use bubble covers that case.
      if (exRegWrite && !exIsLoad && exRd == src) begin
        fwdSel = FWD_EX;
      end else if (memRegWrite && memRd == src) begin
        fwdSel = FWD_MEM;
      end else if (wbRegWrite && wbRd == src) begin
        fwdSel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: stalls, squashes, memory
// freeze, operand forwarding and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = 4,
  parameter int BRANCH_SHADOW = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_rn_used,
  input  logic                  id_rm_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  mem_start,
  input  logic                  mem_done,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  busy
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(REG_PC);
  localparam logic [1:0] SHADOW_INIT =
    (BRANCH_SHADOW > 0) ? 2'(BRANCH_SHADOW - 1) : 2'd0;

  ctrlState_t state;
  logic [1:0] sqCnt;
  logic       memStall;
  logic       loadUse;

  assign memStall = mem_start && !mem_done;
  assign loadUse  = ex_is_load && ex_reg_write && (ex_rd != PC_ADDR) &&
                    ((id_rn_used && id_rn == ex_rd) ||
                     (id_rm_used && id_rm == ex_rd));
  assign busy     = (state != RUN);

  fwd_select #(.ADDR_W(REG_ADDR_W)) fwdRn (
    .src        (id_rn),
    .exRd       (ex_rd),
    .exRegWrite (ex_reg_write),
    .exIsLoad   (ex_is_load),
    .memRd      (mem_rd),
    .memRegWrite(mem_reg_write),
    .wbRd       (wb_rd),
    .wbRegWrite (wb_reg_write),
    .fwdSel     (fwd_a)
  );

  fwd_select #(.ADDR_W(REG_ADDR_W)) fwdRm (
    .src        (id_rm),
    .exRd       (ex_rd),
    .exRegWrite (ex_reg_write),
    .exIsLoad   (ex_is_load),
    .memRd      (mem_rd),
    .memRegWrite(mem_reg_write),
    .wbRd       (wb_rd),
    .wbRegWrite (wb_reg_write),
    .fwdSel     (fwd_b)
  );

  // Pipeline register controls; priority is memory stall > branch > load-use.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (state)
      RUN: begin
        if (memStall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (loadUse) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      SQUASH: begin
        if_id_flush = 1'b1;
      end
      MEM_WAIT: begin
        if (!mem_done) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      sqCnt        <= 2'd0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (memStall) begin
            state <= MEM_WAIT;
          end else if (ex_branch_taken && BRANCH_SHADOW > 0) begin
            state <= SQUASH;
            sqCnt <= SHADOW_INIT;
          end
        end
        SQUASH: begin
          // Execute holds a bubble here, so a branch pulse cannot be real.
          if (sqCnt == 2'd0) begin
            state <= RUN;
          end else begin
            sqCnt <= sqCnt - 2'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase

      if (!pc_en && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string      name;
    logic [3:0] en;   // {pc_en, if_id_en, id_ex_en, ex_mem_en}
    logic [1:0] fl;   // {if_id_flush, id_ex_flush}
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] sc;
    logic       bsy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic       id_rn_used, id_rm_used;
  logic       ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write;
  logic       ex_branch_taken, mem_start, mem_done;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cycles;
  logic       busy;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W   (4),
    .BRANCH_SHADOW(1),
    .CNT_W        (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_rn_used     (id_rn_used),
    .id_rm_used     (id_rm_used),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_is_load     (ex_is_load),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .mem_start      (mem_start),
    .mem_done       (mem_done),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .stall_cycles   (stall_cycles),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [3:0] aEn;
    logic [1:0] aFl;
    aEn = {pc_en, if_id_en, id_ex_en, ex_mem_en};
    aFl = {if_id_flush, id_ex_flush};
    total++;
    if (aEn !== e.en || aFl !== e.fl || fwd_a !== e.fa || fwd_b !== e.fb ||
        stall_cycles !== e.sc || busy !== e.bsy) begin
      bad++;
      $display("FAIL %s: got en=%b fl=%b fa=%b fb=%b sc=%0d busy=%b, want en=%b fl=%b fa=%b fb=%b sc=%0d busy=%b",
               e.name, aEn, aFl, fwd_a, fwd_b, stall_cycles, busy,
               e.en, e.fl, e.fa, e.fb, e.sc, e.bsy);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) check(expQ.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string n, input logic [3:0] en,
                              input logic [1:0] fl, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [3:0] sc,
                              input logic bsy);
    exp_t e;
    e.name = n; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = sc; e.bsy = bsy;
    expQ.push_back(e);
    tick();
  endtask

  task automatic idle_inputs();
    id_rn = 4'd0; id_rm = 4'd0; id_rn_used = 1'b0; id_rm_used = 1'b0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    mem_rd = 4'd0; mem_reg_write = 1'b0;
    wb_rd = 4'd0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; mem_start = 1'b0; mem_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    expect_cycle("reset_state", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);

    // Load-use: LDR r3 in EX, ADD r1,r3,r2 in ID.
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
    id_rn = 4'd3; id_rn_used = 1'b1; id_rm = 4'd2; id_rm_used = 1'b1;
    expect_cycle("loaduse_rn", 4'b0011, 2'b01, 2'b00, 2'b00, 4'd0, 1'b0);
    ex_is_load = 1'b0; ex_reg_write = 1'b0; ex_rd = 4'd0;
    mem_rd = 4'd3; mem_reg_write = 1'b1;
    expect_cycle("loaduse_after", 4'b1111, 2'b00, 2'b10, 2'b00, 4'd1, 1'b0);
    idle_inputs();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd7;
    id_rn = 4'd2; id_rn_used = 1'b1; id_rm = 4'd7; id_rm_used = 1'b1;
    expect_cycle("loaduse_rm", 4'b0011, 2'b01, 2'b00, 2'b00, 4'd1, 1'b0);

    // No load-use: destination is r15, or the matching source is unused.
    idle_inputs();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd15;
    id_rn = 4'd15; id_rn_used = 1'b1;
    expect_cycle("load_r15", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd2, 1'b0);
    ex_rd = 4'd4; id_rn = 4'd1; id_rm = 4'd4; id_rm_used = 1'b0;
    expect_cycle("load_unused", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd2, 1'b0);

    // Forwarding priority EX > MEM > WB, r15 never forwarded.
    idle_inputs();
    ex_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
    ex_reg_write = 1'b1; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    id_rn = 4'd5; id_rn_used = 1'b1; id_rm = 4'd5; id_rm_used = 1'b1;
    expect_cycle("fwd_ex", 4'b1111, 2'b00, 2'b01, 2'b01, 4'd2, 1'b0);
    ex_reg_write = 1'b0;
    expect_cycle("fwd_mem", 4'b1111, 2'b00, 2'b10, 2'b10, 4'd2, 1'b0);
    mem_reg_write = 1'b0;
    expect_cycle("fwd_wb", 4'b1111, 2'b00, 2'b11, 2'b11, 4'd2, 1'b0);
    id_rn = 4'd15;
    expect_cycle("fwd_r15", 4'b1111, 2'b00, 2'b00, 2'b11, 4'd2, 1'b0);
    idle_inputs();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd5;
    mem_rd = 4'd5; mem_reg_write = 1'b1; id_rn = 4'd5; id_rm = 4'd6;
    expect_cycle("fwd_skip_load", 4'b1111, 2'b00, 2'b10, 2'b00, 4'd2, 1'b0);

    // Taken branch with one shadow cycle.
    idle_inputs();
    ex_branch_taken = 1'b1;
    expect_cycle("br_n", 4'b1111, 2'b11, 2'b00, 2'b00, 4'd2, 1'b0);
    ex_branch_taken = 1'b0;
    expect_cycle("br_shadow", 4'b1111, 2'b10, 2'b00, 2'b00, 4'd2, 1'b1);
    expect_cycle("br_done", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd2, 1'b0);

    // Branch beats load-use; a branch during SQUASH is ignored.
    ex_branch_taken = 1'b1;
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
    id_rn = 4'd3; id_rn_used = 1'b1;
    expect_cycle("br_over_lu", 4'b1111, 2'b11, 2'b00, 2'b00, 4'd2, 1'b0);
    idle_inputs();
    ex_branch_taken = 1'b1;
    expect_cycle("br_in_squash", 4'b1111, 2'b10, 2'b00, 2'b00, 4'd2, 1'b1);
    ex_branch_taken = 1'b0;
    expect_cycle("br_ignored", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd2, 1'b0);

    // Memory wait, three cycles with mem_done low, branch ignored.
    mem_start = 1'b1;
    expect_cycle("mem_start", 4'b0000, 2'b00, 2'b00, 2'b00, 4'd2, 1'b0);
    mem_start = 1'b0; ex_branch_taken = 1'b1;
    expect_cycle("mem_wait1", 4'b0000, 2'b00, 2'b00, 2'b00, 4'd3, 1'b1);
    ex_branch_taken = 1'b0;
    expect_cycle("mem_wait2", 4'b0000, 2'b00, 2'b00, 2'b00, 4'd4, 1'b1);
    mem_done = 1'b1;
    expect_cycle("mem_done", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd5, 1'b1);
    mem_done = 1'b0;
    expect_cycle("mem_back_run", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd5, 1'b0);

    // Zero-wait access.
    mem_start = 1'b1; mem_done = 1'b1;
    expect_cycle("mem_zero_wait", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd5, 1'b0);
    mem_start = 1'b0; mem_done = 1'b0;
    expect_cycle("mem_zero_after", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd5, 1'b0);

    // Memory stall beats branch, then reset mid-wait.
    mem_start = 1'b1; ex_branch_taken = 1'b1;
    expect_cycle("mem_over_br", 4'b0000, 2'b00, 2'b00, 2'b00, 4'd5, 1'b0);
    mem_start = 1'b0; ex_branch_taken = 1'b0;
    expect_cycle("mem_wait_pre_rst", 4'b0000, 2'b00, 2'b00, 2'b00, 4'd6, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_cycle("rst_mid_wait", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);

    // Reset mid-squash.
    ex_branch_taken = 1'b1;
    expect_cycle("br_pre_rst", 4'b1111, 2'b11, 2'b00, 2'b00, 4'd0, 1'b0);
    ex_branch_taken = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_cycle("rst_mid_squash", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0);

    // Saturation: 4-bit counter held in MEM_WAIT for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      mem_start = (i == 0);
      expect_cycle("sat_wait", 4'b0000, 2'b00, 2'b00, 2'b00,
                   (i > 15) ? 4'd15 : 4'(i), (i != 0));
    end
    mem_start = 1'b0; mem_done = 1'b1;
    expect_cycle("sat_done", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd15, 1'b1);
    mem_done = 1'b0;
    expect_cycle("sat_hold", 4'b1111, 2'b00, 2'b00, 2'b00, 4'd15, 1'b0);

    tick();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
